// File: rtl/icache_controller.sv
// Instruction cache backed by a dictionary-compressed second-level cache; icache hit 1 cycle, comp hit 2 cycles.
// The memory request is held stable until mem_req_ready; proc_ready pulses for exactly one cycle per fetch.
module icache_controller #(
  parameter int ICACHE_LINES = 16,
  parameter int COMP_LINES   = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        proc_valid,
  output logic        proc_ready,
  input  logic [31:0] proc_addr,
  output logic [31:0] proc_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic [31:0] mem_req_rdata,
  input  logic        dict1_write_enable,
  input  logic        dict2_write_enable,
  input  logic        dict3_write_enable,
  input  logic [6:0]  dict1_write_val,
  input  logic [9:0]  dict2_write_val,
  input  logic [14:0] dict3_write_val,
  output logic        debug_icache_miss,
  output logic        debug_comp_cache_miss,
  output logic [31:0] debug_icache_occupancy,
  output logic [31:0] debug_comp_occupancy
);

  localparam int IW  = $clog2(ICACHE_LINES);
  localparam int CW  = $clog2(COMP_LINES);
  localparam int ITW = 30 - IW;
  localparam int CTW = 30 - CW;

  typedef enum logic [2:0] {IDLE, RESP, DECOMP, MEM_REQ, FILL} state_t;

  state_t state_q, state_d;

  logic [ICACHE_LINES-1:0] ic_valid;
  logic [ITW-1:0]          ic_tag  [ICACHE_LINES];
  logic [31:0]             ic_data [ICACHE_LINES];
  logic [COMP_LINES-1:0]   cc_valid;
  logic [CTW-1:0]          cc_tag  [COMP_LINES];
  logic [15:0]             cc_code [COMP_LINES];

  logic [6:0]  d1 [8];
  logic [9:0]  d2 [32];
  logic [14:0] d3 [256];
  logic [2:0]  d1_ptr;
  logic [4:0]  d2_ptr;
  logic [7:0]  d3_ptr;

  logic [29:0] addr_q;
  logic [31:0] fill_q;

  // Low address bits select a byte within the word and play no part in lookup.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^proc_addr[1:0];

  logic [IW-1:0] lk_iidx;
  logic [CW-1:0] lk_cidx;
  logic          ic_hit, cc_hit;
  assign lk_iidx = proc_addr[IW+1:2];
  assign lk_cidx = proc_addr[CW+1:2];
  assign ic_hit  = ic_valid[lk_iidx] && (ic_tag[lk_iidx] == proc_addr[31:IW+2]);
  assign cc_hit  = cc_valid[lk_cidx] && (cc_tag[lk_cidx] == proc_addr[31:CW+2]);

  logic [IW-1:0]  q_iidx;
  logic [ITW-1:0] q_itag;
  logic [CW-1:0]  q_cidx;
  logic [CTW-1:0] q_ctag;
  assign q_iidx = addr_q[IW-1:0];
  assign q_itag = addr_q[29:IW];
  assign q_cidx = addr_q[CW-1:0];
  assign q_ctag = addr_q[29:CW];

  logic [15:0] dec_code;
  logic [31:0] dec_word;
  assign dec_code = cc_code[q_cidx];
  assign dec_word = {d1[dec_code[15:13]], d2[dec_code[12:8]], d3[dec_code[7:0]]};

  // Lowest-index match per dictionary; a code is only stored when all three fields match.
  logic       m1_hit, m2_hit, m3_hit, fill_match;
  logic [2:0] m1_idx;
  logic [4:0] m2_idx;
  logic [7:0] m3_idx;
  logic [15:0] fill_code;

  always_comb begin
    m1_hit = 1'b0;
    m2_hit = 1'b0;
    m3_hit = 1'b0;
    m1_idx = '0;
    m2_idx = '0;
    m3_idx = '0;
    for (int i = 0; i < 8; i++)
      if (!m1_hit && d1[i] == fill_q[31:25]) begin
        m1_hit = 1'b1;
        m1_idx = 3'(i);
      end
    for (int i = 0; i < 32; i++)
      if (!m2_hit && d2[i] == fill_q[24:15]) begin
        m2_hit = 1'b1;
        m2_idx = 5'(i);
      end
    for (int i = 0; i < 256; i++)
      if (!m3_hit && d3[i] == fill_q[14:0]) begin
        m3_hit = 1'b1;
        m3_idx = 8'(i);
      end
  end

  assign fill_match = m1_hit && m2_hit && m3_hit;
  assign fill_code  = {m1_idx, m2_idx, m3_idx};
  assign mem_req_addr = {addr_q, 2'b00};

  logic        lookup, fill_cap, ic_we, cc_we, rdata_we;
  logic [31:0] ic_wdata, rdata_d;

  always_comb begin
    state_d       = state_q;
    proc_ready    = 1'b0;
    mem_req_valid = 1'b0;
    lookup        = 1'b0;
    fill_cap      = 1'b0;
    ic_we         = 1'b0;
    cc_we         = 1'b0;
    rdata_we      = 1'b0;
    ic_wdata      = fill_q;
    rdata_d       = fill_q;
    case (state_q)
      IDLE: begin
        if (proc_valid) begin
          lookup = 1'b1;
          if (ic_hit) begin
            state_d  = RESP;
            rdata_we = 1'b1;
            rdata_d  = ic_data[lk_iidx];
          end else if (cc_hit) begin
            state_d = DECOMP;
          end else begin
            state_d = MEM_REQ;
          end
        end
      end
      DECOMP: begin
        ic_we    = 1'b1;
        ic_wdata = dec_word;
        rdata_we = 1'b1;
        rdata_d  = dec_word;
        state_d  = RESP;
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          fill_cap = 1'b1;
          state_d  = FILL;
        end
      end
      FILL: begin
        ic_we    = 1'b1;
        cc_we    = fill_match;
        rdata_we = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        proc_ready = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      addr_q                 <= '0;
      fill_q                 <= '0;
      proc_rdata             <= '0;
      ic_valid               <= '0;
      cc_valid               <= '0;
      debug_icache_occupancy <= '0;
      debug_comp_occupancy   <= '0;
      debug_icache_miss      <= 1'b0;
      debug_comp_cache_miss  <= 1'b0;
      d1_ptr                 <= '0;
      d2_ptr                 <= '0;
      d3_ptr                 <= '0;
    end else begin
      debug_icache_miss     <= lookup && !ic_hit;
      debug_comp_cache_miss <= lookup && !cc_hit;
      if (lookup)   addr_q     <= proc_addr[31:2];
      if (fill_cap) fill_q     <= mem_req_rdata;
      if (rdata_we) proc_rdata <= rdata_d;
      if (ic_we) begin
        ic_valid[q_iidx] <= 1'b1;
        if (!ic_valid[q_iidx]) debug_icache_occupancy <= debug_icache_occupancy + 32'd1;
      end
      if (cc_we) begin
        cc_valid[q_cidx] <= 1'b1;
        if (!cc_valid[q_cidx]) debug_comp_occupancy <= debug_comp_occupancy + 32'd1;
      end
      if (dict1_write_enable) d1_ptr <= d1_ptr + 3'd1;
      if (dict2_write_enable) d2_ptr <= d2_ptr + 5'd1;
      if (dict3_write_enable) d3_ptr <= d3_ptr + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (ic_we) begin
      ic_tag[q_iidx]  <= q_itag;
      ic_data[q_iidx] <= ic_wdata;
    end
    if (cc_we) begin
      cc_tag[q_cidx]  <= q_ctag;
      cc_code[q_cidx] <= fill_code;
    end
  end

  // Dictionary contents deliberately survive reset; only the write pointers clear.
  always_ff @(posedge clk) begin
    if (!resetn && dict1_write_enable) d1[d1_ptr] <= dict1_write_val;
    if (!resetn && dict2_write_enable) d2[d2_ptr] <= dict2_write_val;
    if (!resetn && dict3_write_enable) d3[d3_ptr] <= dict3_write_val;
  end

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller: cold/warm fetches, compressed refill, memory stall, reset abort, dictionary wrap.
module tb_icache_controller;

  logic        clk = 1'b0;
  logic        resetn;
  logic        proc_valid, proc_ready;
  logic [31:0] proc_addr, proc_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr, mem_req_rdata;
  logic        dict1_write_enable, dict2_write_enable, dict3_write_enable;
  logic [6:0]  dict1_write_val;
  logic [9:0]  dict2_write_val;
  logic [14:0] dict3_write_val;
  logic        debug_icache_miss, debug_comp_cache_miss;
  logic [31:0] debug_icache_occupancy, debug_comp_occupancy;

  int tests = 0;
  int fails = 0;

  // Results of the most recent fetch
  logic [31:0] f_word, f_maddr;
  int          f_lat, f_mcyc;
  logic        f_imiss, f_cmiss, f_stable, f_rdy_early, f_one, f_done;

  icache_controller #(.ICACHE_LINES(16), .COMP_LINES(64)) dut (
    .clk(clk), .resetn(resetn),
    .proc_valid(proc_valid), .proc_ready(proc_ready),
    .proc_addr(proc_addr), .proc_rdata(proc_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rdata(mem_req_rdata),
    .dict1_write_enable(dict1_write_enable), .dict2_write_enable(dict2_write_enable),
    .dict3_write_enable(dict3_write_enable),
    .dict1_write_val(dict1_write_val), .dict2_write_val(dict2_write_val),
    .dict3_write_val(dict3_write_val),
    .debug_icache_miss(debug_icache_miss), .debug_comp_cache_miss(debug_comp_cache_miss),
    .debug_icache_occupancy(debug_icache_occupancy), .debug_comp_occupancy(debug_comp_occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] == 30'h0 || a[31:2] == 30'h10) return 32'h0000_0013;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int delay);
    f_word = '0; f_maddr = '0; f_lat = 0; f_mcyc = 0;
    f_imiss = 0; f_cmiss = 0; f_stable = 1; f_rdy_early = 0; f_one = 0; f_done = 0;
    @(negedge clk);
    proc_valid = 1'b1;
    proc_addr  = a;
    @(posedge clk); #1;
    proc_valid = 1'b0;
    proc_addr  = '0;
    for (int c = 1; c <= 40 && !f_done; c++) begin
      if (debug_icache_miss)     f_imiss = 1;
      if (debug_comp_cache_miss) f_cmiss = 1;
      if (mem_req_valid) begin
        if (f_mcyc == 0) f_maddr = mem_req_addr;
        else if (mem_req_addr !== f_maddr) f_stable = 0;
        if (proc_ready) f_rdy_early = 1;
        f_mcyc++;
        if (f_mcyc > delay) begin
          mem_req_ready = 1'b1;
          mem_req_rdata = mem_word(mem_req_addr);
        end
      end
      if (proc_ready) begin
        f_word = proc_rdata;
        f_lat  = c;
        f_done = 1;
      end else begin
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        mem_req_rdata = '0;
      end
    end
    check("fetch_completed", {31'b0, f_done}, 32'd1);
    @(posedge clk); #1;
    f_one = !proc_ready && !mem_req_valid;
  endtask

  task automatic expect_fetch(input string n, input logic [31:0] word, input int lat,
                              input logic imiss, input logic cmiss, input int mcyc);
    check({n, "_word"},    f_word, word);
    check({n, "_latency"}, 32'(f_lat), 32'(lat));
    check({n, "_imiss"},   {31'b0, f_imiss}, {31'b0, imiss});
    check({n, "_cmiss"},   {31'b0, f_cmiss}, {31'b0, cmiss});
    check({n, "_memreqs"}, 32'(f_mcyc), 32'(mcyc));
    check({n, "_ready_one_cycle"}, {31'b0, f_one}, 32'd1);
  endtask

  initial begin
    resetn = 1'b1;
    proc_valid = 1'b0; proc_addr = '0;
    mem_req_ready = 1'b0; mem_req_rdata = '0;
    dict1_write_enable = 1'b0; dict2_write_enable = 1'b0; dict3_write_enable = 1'b0;
    dict1_write_val = '0; dict2_write_val = '0; dict3_write_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_proc_ready", {31'b0, proc_ready}, 32'd0);
    check("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_proc_rdata", proc_rdata, 32'd0);
    check("rst_icache_occ", debug_icache_occupancy, 32'd0);
    check("rst_comp_occ", debug_comp_occupancy, 32'd0);
    check("rst_miss_pulses", {30'b0, debug_icache_miss, debug_comp_cache_miss}, 32'd0);
    @(negedge clk);
    resetn = 1'b0;

    // Fill all dictionaries with values that never match; every pointer wraps back to 0
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      dict1_write_enable = (i < 8);
      dict2_write_enable = (i < 32);
      dict3_write_enable = 1'b1;
      dict1_write_val = 7'h7F;
      dict2_write_val = 10'h3FF;
      dict3_write_val = 15'h7FFF;
    end
    @(negedge clk);
    dict1_write_enable = 1'b0; dict2_write_enable = 1'b0; dict3_write_enable = 1'b0;

    // Cold fetch of 0x0: both caches miss, no dictionary match
    fetch(32'h0, 0);
    expect_fetch("cold0", 32'h0000_0013, 3, 1, 1, 1);
    check("cold0_mem_addr", f_maddr, 32'h0);
    check("cold0_icache_occ", debug_icache_occupancy, 32'd1);
    check("cold0_comp_occ", debug_comp_occupancy, 32'd0);

    // Warm refetch, and a byte offset in the same word
    fetch(32'h0, 0);
    expect_fetch("warm0", 32'h0000_0013, 1, 0, 1, 0);
    fetch(32'h3, 0);
    expect_fetch("warm3", 32'h0000_0013, 1, 0, 1, 0);

    // Make 0x00000013 compressible: code 0 = {D1[0],D2[0],D3[0]}
    @(negedge clk);
    dict1_write_enable = 1'b1; dict1_write_val = 7'h00;
    dict2_write_enable = 1'b1; dict2_write_val = 10'h000;
    dict3_write_enable = 1'b1; dict3_write_val = 15'h0013;
    @(negedge clk);
    dict1_write_enable = 1'b0; dict2_write_enable = 1'b0; dict3_write_enable = 1'b0;

    fetch(32'h40, 0);
    expect_fetch("fill40", 32'h0000_0013, 3, 1, 1, 1);
    check("fill40_mem_addr", f_maddr, 32'h40);
    check("fill40_icache_occ_replace", debug_icache_occupancy, 32'd1);
    check("fill40_comp_occ", debug_comp_occupancy, 32'd1);

    fetch(32'h0, 0);
    expect_fetch("evict0", 32'h0000_0013, 3, 1, 1, 1);
    check("evict0_comp_occ", debug_comp_occupancy, 32'd2);

    fetch(32'h40, 0);
    expect_fetch("decomp40", 32'h0000_0013, 2, 1, 0, 0);
    check("decomp40_icache_occ", debug_icache_occupancy, 32'd1);

    // Memory stall of 5 cycles
    fetch(32'h104, 5);
    expect_fetch("stall104", 32'hFEFB_0104, 8, 1, 1, 6);
    check("stall104_addr", f_maddr, 32'h104);
    check("stall104_addr_stable", {31'b0, f_stable}, 32'd1);
    check("stall104_no_early_ready", {31'b0, f_rdy_early}, 32'd0);
    check("stall104_icache_occ", debug_icache_occupancy, 32'd2);
    check("stall104_comp_occ", debug_comp_occupancy, 32'd2);

    // Reset in the middle of a memory request
    @(negedge clk);
    proc_valid = 1'b1; proc_addr = 32'h80;
    @(posedge clk); #1;
    proc_valid = 1'b0; proc_addr = '0;
    check("abort_in_memreq", {31'b0, mem_req_valid}, 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    #1;
    check("abort_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("abort_mem_req_addr", mem_req_addr, 32'd0);
    check("abort_proc_ready", {31'b0, proc_ready}, 32'd0);
    check("abort_proc_rdata", proc_rdata, 32'd0);
    check("abort_icache_occ", debug_icache_occupancy, 32'd0);
    check("abort_comp_occ", debug_comp_occupancy, 32'd0);
    @(negedge clk);
    resetn = 1'b0;

    fetch(32'h80, 0);
    expect_fetch("after_abort80", 32'hFF7F_0080, 3, 1, 1, 1);
    check("after_abort80_mem_addr", f_maddr, 32'h80);
    check("after_abort80_icache_occ", debug_icache_occupancy, 32'd1);

    // Nine writes to D1 from pointer 0: the ninth lands in entry 0
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      dict1_write_enable = 1'b1;
      dict1_write_val = (i == 8) ? 7'h00 : 7'(8'h10 + i);
    end
    @(negedge clk);
    dict1_write_enable = 1'b0;

    fetch(32'h0, 0);
    expect_fetch("wrap0", 32'h0000_0013, 3, 1, 1, 1);
    check("wrap0_comp_occ", debug_comp_occupancy, 32'd1);
    fetch(32'h40, 0);
    expect_fetch("wrap40", 32'h0000_0013, 3, 1, 1, 1);
    check("wrap40_comp_occ", debug_comp_occupancy, 32'd2);
    fetch(32'h0, 0);
    expect_fetch("wrap_decomp0", 32'h0000_0013, 2, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
